instr_readback_checker: RTL and testbench

Downstream stage of the instruction register: sweeps a programmed address range through the register's read port, recomputes each entry's expected result from its stored opcode and operands, and streams every entry with a mismatch flag over a valid/ready interface. A running error count and a done pulse let the testbench or a status block confirm the register contents in one pass.

---
 rtl/instr_register_pkg.sv | 70 +++++++
 rtl/instr_readback_checker_if.sv | 40 ++++
 rtl/instr_result_model.sv | 16 +
 rtl/instr_readback_checker.sv | 131 +++++++++++++
 tb/tb_instr_readback_checker.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/instr_register_pkg.sv
// Shared types and arithmetic rules for the instruction register and its
// readback checker.
//   - operand_t / result_t : signed operand and full-width result types
//   - opcode_t             : 4-bit opcode; encodings above MOD are reserved
//   - address_t            : register entry index (NUM_ENTRIES entries)
//   - instruction_t        : one stored entry {opc, op_a, op_b, result}
//   - state_t              : readback checker FSM states (exposed for debug)
//   - calc_result()        : the one definition of the arithmetic rules,
//                            used by both the write stage and the checker
package instr_register_pkg;

  localparam int NUM_ENTRIES = 32;
  localparam int ERR_W       = 6;
  localparam int ADDR_W      = $clog2(NUM_ENTRIES);

  typedef logic signed [31:0] operand_t;
  typedef logic signed [63:0] result_t;

  typedef enum logic [3:0] {
    ZERO  = 4'd0,
    PASSA = 4'd1,
    PASSB = 4'd2,
    ADD   = 4'd3,
    SUB   = 4'd4,
    MULT  = 4'd5,
    DIV   = 4'd6,
    MOD   = 4'd7
  } opcode_t;

  typedef logic [ADDR_W-1:0] address_t;

  typedef struct packed {
    opcode_t  opc;
    operand_t op_a;
    operand_t op_b;
    result_t  result;
  } instruction_t;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_CHECK = 3'd2,
    S_OUT   = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  // Operands are sign-extended to the result width first so that MULT keeps
  // the full 64-bit product and DIV of the most negative value by -1 does
  // not overflow. SV signed '/' truncates toward zero and '%' takes the sign
  // of the dividend. Division by zero and reserved opcodes yield 0.
  function automatic result_t calc_result(opcode_t opc, operand_t a, operand_t b);
    result_t wa;
    result_t wb;
    result_t res;
    wa = a;
    wb = b;
    case (opc)
      PASSA:   res = wa;
      PASSB:   res = wb;
      ADD:     res = wa + wb;
      SUB:     res = wa - wb;
      MULT:    res = wa * wb;
      DIV:     res = (b == 32'sd0) ? '0 : wa / wb;
      MOD:     res = (b == 32'sd0) ? '0 : wa % wb;
      default: res = '0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/instr_readback_checker_if.sv
// Read port and output stream of the readback checker.
//   read_pointer     : checker -> register, read address
//   instruction_word : register -> checker, combinational read data
//   out_valid/out_ready/out_addr/out_instr/out_mismatch : entry stream
//
// Handshake: an entry transfers on a rising clk edge where out_valid and
// out_ready are both 1. While out_valid=1 and out_ready=0 the producer holds
// out_addr, out_instr and out_mismatch stable and keeps out_valid high.
// out_ready may be asserted at any time and has no effect while out_valid=0.
interface instr_readback_checker_if;
  import instr_register_pkg::*;

  address_t     read_pointer;
  instruction_t instruction_word;
  logic         out_valid;
  logic         out_ready;
  address_t     out_addr;
  instruction_t out_instr;
  logic         out_mismatch;

  modport master (
    output read_pointer,
    input  instruction_word,
    output out_valid,
    input  out_ready,
    output out_addr,
    output out_instr,
    output out_mismatch
  );

  modport slave (
    input  read_pointer,
    output instruction_word,
    input  out_valid,
    output out_ready,
    input  out_addr,
    input  out_instr,
    input  out_mismatch
  );
endinterface

// File: rtl/instr_result_model.sv
// Combinational recompute of an entry's expected result from its opcode and
// operands.
//   opc, op_a, op_b : stored entry fields
//   result          : value the entry should hold
module instr_result_model
  import instr_register_pkg::*;
(
  input  opcode_t  opc,
  input  operand_t op_a,
  input  operand_t op_b,
  output result_t  result
);

  assign result = calc_result(opc, op_a, op_b);

endmodule

// File: rtl/instr_readback_checker.sv
// Sweeps an address range of the instruction register, recomputes each
// entry's result, and streams every entry with a mismatch flag.
//   clk, reset_n          : clock, asynchronous active-low reset
//   start                 : begin a sweep (only honoured in IDLE)
//   first_addr, last_addr : inclusive sweep range, wraps modulo NUM_ENTRIES
//   bus                   : read port + output stream (master side)
//   busy                  : high in every state except IDLE
//   done                  : one-cycle pulse after the last entry transfers
//   err_count             : mismatches in the current or last sweep
//   state_dbg             : current FSM state
module instr_readback_checker
  import instr_register_pkg::*;
(
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      start,
  input  address_t                  first_addr,
  input  address_t                  last_addr,
  instr_readback_checker_if.master  bus,
  output logic                      busy,
  output logic                      done,
  output logic [ERR_W-1:0]          err_count,
  output state_t                    state_dbg
);

  state_t           state_q, state_d;
  address_t         rp_q, rp_d;
  address_t         last_q, last_d;
  logic             out_valid_q, out_valid_d;
  address_t         out_addr_q, out_addr_d;
  instruction_t     out_instr_q, out_instr_d;
  logic             out_mismatch_q, out_mismatch_d;
  logic [ERR_W-1:0] err_count_q, err_count_d;

  result_t          expected_result;

  // Recompute from the captured entry, so the comparison in CHECK sees the
  // same fields that are later presented on the stream.
  instr_result_model u_result_model (
    .opc    (out_instr_q.opc),
    .op_a   (out_instr_q.op_a),
    .op_b   (out_instr_q.op_b),
    .result (expected_result)
  );

  always_comb begin
    state_d        = state_q;
    rp_d           = rp_q;
    last_d         = last_q;
    out_valid_d    = out_valid_q;
    out_addr_d     = out_addr_q;
    out_instr_d    = out_instr_q;
    out_mismatch_d = out_mismatch_q;
    err_count_d    = err_count_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          last_d      = last_addr;
          rp_d        = first_addr;
          err_count_d = '0;
          state_d     = S_READ;
        end
      end
      S_READ: begin
        out_instr_d = bus.instruction_word;
        out_addr_d  = rp_q;
        state_d     = S_CHECK;
      end
      S_CHECK: begin
        out_mismatch_d = (out_instr_q.result != expected_result);
        if (out_instr_q.result != expected_result) begin
          err_count_d = err_count_q + ERR_W'(1);
        end
        out_valid_d = 1'b1;
        state_d     = S_OUT;
      end
      S_OUT: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          if (out_addr_q == last_q) begin
            state_d = S_DONE;
          end else begin
            // address_t is exactly log2(NUM_ENTRIES) wide, so this wraps.
            rp_d    = rp_q + address_t'(1);
            state_d = S_READ;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= S_IDLE;
      rp_q           <= '0;
      last_q         <= '0;
      out_valid_q    <= 1'b0;
      out_addr_q     <= '0;
      out_instr_q    <= '{opc: ZERO, op_a: '0, op_b: '0, result: '0};
      out_mismatch_q <= 1'b0;
      err_count_q    <= '0;
    end else begin
      state_q        <= state_d;
      rp_q           <= rp_d;
      last_q         <= last_d;
      out_valid_q    <= out_valid_d;
      out_addr_q     <= out_addr_d;
      out_instr_q    <= out_instr_d;
      out_mismatch_q <= out_mismatch_d;
      err_count_q    <= err_count_d;
    end
  end

  assign bus.read_pointer = rp_q;
  assign bus.out_valid    = out_valid_q;
  assign bus.out_addr     = out_addr_q;
  assign bus.out_instr    = out_instr_q;
  assign bus.out_mismatch = out_mismatch_q;
  assign busy             = (state_q != S_IDLE);
  assign done             = (state_q == S_DONE);
  assign err_count        = err_count_q;
  assign state_dbg        = state_q;

endmodule

// File: tb/tb_instr_readback_checker.sv
module tb_instr_readback_checker;
  import instr_register_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  logic             start;
  address_t         first_addr;
  address_t         last_addr;
  logic             busy;
  logic             done;
  logic [ERR_W-1:0] err_count;
  state_t           state_dbg;

  instr_readback_checker_if bus_if ();

  instr_readback_checker dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .first_addr (first_addr),
    .last_addr  (last_addr),
    .bus        (bus_if.master),
    .busy       (busy),
    .done       (done),
    .err_count  (err_count),
    .state_dbg  (state_dbg)
  );

  // Register contents, read combinationally like the real register.
  instruction_t mem [NUM_ENTRIES];
  assign bus_if.instruction_word = mem[bus_if.read_pointer];

  int pass_cnt = 0;
  int fail_cnt = 0;
  int total    = 0;

  // ---------------- reference model ----------------
  function automatic longint ref_result(logic [3:0] opc, int a, int b);
    longint la = a;
    longint lb = b;
    case (opc)
      4'd1: return la;
      4'd2: return lb;
      4'd3: return la + lb;
      4'd4: return la - lb;
      4'd5: return la * lb;
      4'd6: return (b == 0) ? 64'sd0 : la / lb;
      4'd7: return (b == 0) ? 64'sd0 : la % lb;
      default: return 64'sd0;
    endcase
  endfunction

  task automatic check(input string tag, input logic [135:0] obs, input logic [135:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_entry(input int idx, input logic [3:0] opc, input int a, input int b,
                           input longint res);
    instruction_t e;
    e.opc    = opcode_t'(opc);
    e.op_a   = a;
    e.op_b   = b;
    e.result = res;
    mem[idx] = e;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_rp"},    bus_if.read_pointer, 0);
    check({tag, "_valid"}, bus_if.out_valid, 0);
    check({tag, "_addr"},  bus_if.out_addr, 0);
    check({tag, "_instr"}, bus_if.out_instr, 0);
    check({tag, "_mm"},    bus_if.out_mismatch, 0);
    check({tag, "_busy"},  busy, 0);
    check({tag, "_done"},  done, 0);
    check({tag, "_err"},   err_count, 0);
  endtask

  // ---------------- driver + scoreboard ----------------
  // One sweep first..last. Each entry waits out a stall of stall_min..stall_max
  // cycles with out_ready low; poke_start pulses start inside the stall.
  // abort_at >= 0 asserts reset while that entry index is presented.
  task automatic sweep(input int first, input int last, input int stall_min,
                       input int stall_max, input bit poke_start, input int abort_at);
    int           exp_q[$];
    int           idx;
    int           n;
    int           k;
    int           exp_err;
    bit           exp_mm;
    address_t     held_a;
    instruction_t held_i;

    idx = first;
    exp_q.push_back(idx);
    while (idx != last) begin
      idx = (idx + 1) % NUM_ENTRIES;
      exp_q.push_back(idx);
    end
    exp_err = 0;

    @(negedge clk);
    start      = 1'b1;
    first_addr = address_t'(first);
    last_addr  = address_t'(last);
    @(negedge clk);
    start = 1'b0;
    check("rp_after_start", bus_if.read_pointer, first);
    check("busy_after_start", busy, 1);
    check("err_cleared", err_count, 0);
    check("valid_low_after_start", bus_if.out_valid, 0);

    for (int e = 0; e < exp_q.size(); e++) begin
      idx = exp_q[e];
      n = 0;
      while (!bus_if.out_valid && n < 10) begin
        @(negedge clk);
        n++;
      end
      check("valid_latency", n, 2);
      exp_mm = (mem[idx].result !== ref_result(mem[idx].opc, mem[idx].op_a, mem[idx].op_b));
      if (exp_mm) exp_err++;
      check("out_addr", bus_if.out_addr, idx);
      check("out_instr", bus_if.out_instr, mem[idx]);
      check("out_mismatch", bus_if.out_mismatch, exp_mm);
      check("err_running", err_count, exp_err);
      check("done_mid", done, 0);

      if (e == abort_at) begin
        #2 reset_n = 1'b0;
        #1 check_reset_values("async_reset");
        for (int j = 0; j < 3; j++) begin
          @(negedge clk);
          check("no_done_in_reset", done, 0);
        end
        reset_n = 1'b1;
        @(negedge clk);
        check_reset_values("after_abort");
        return;
      end

      k      = $urandom_range(stall_min, stall_max);
      held_a = bus_if.out_addr;
      held_i = bus_if.out_instr;
      for (int j = 0; j < k; j++) begin
        if (poke_start && j == 1) begin
          start      = 1'b1;
          first_addr = address_t'((first + 5) % NUM_ENTRIES);
          last_addr  = address_t'((first + 6) % NUM_ENTRIES);
        end
        @(negedge clk);
        start = 1'b0;
        check("stall_valid", bus_if.out_valid, 1);
        check("stall_addr", bus_if.out_addr, held_a);
        check("stall_instr", bus_if.out_instr, held_i);
      end

      bus_if.out_ready = 1'b1;
      @(negedge clk);
      bus_if.out_ready = 1'b0;
      check("valid_dropped", bus_if.out_valid, 0);
      if (e == exp_q.size() - 1) check("done_pulse", done, 1);
      else                       check("no_early_done", done, 0);
    end

    @(negedge clk);
    check("done_one_cycle", done, 0);
    check("idle_after_sweep", busy, 0);
    check("err_final", err_count, exp_err);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int   opc;
    int   a;
    int   b;
    longint r;

    reset_n          = 1'b0;
    start            = 1'b0;
    first_addr       = '0;
    last_addr        = '0;
    bus_if.out_ready = 1'b0;

    for (int i = 0; i < NUM_ENTRIES; i++) begin
      opc = $urandom_range(0, 9);
      a   = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 200) - 100 : int'($urandom);
      b   = ($urandom_range(0, 5) == 0) ? 0
          : (($urandom_range(0, 1) == 0) ? $urandom_range(0, 200) - 100 : int'($urandom));
      r   = ref_result(4'(opc), a, b);
      if ($urandom_range(0, 3) == 0) r = r + 1;
      set_entry(i, 4'(opc), a, b, r);
    end
    set_entry(4, 4'd3, 5, -3, 2);
    set_entry(7, 4'd6, 9, 0, 0);
    set_entry(8, 4'd5, -70000, 70000, -64'sd4900000000);
    set_entry(3, 4'd4, 10, 4, 5);

    repeat (3) @(negedge clk);
    check_reset_values("in_reset");
    reset_n = 1'b1;
    @(negedge clk);
    check_reset_values("post_reset");

    // Single correct ADD entry.
    sweep(4, 4, 0, 0, 1'b0, -1);
    check("add_err_zero", err_count, 0);

    // DIV by zero and full-width MULT, both stored correctly.
    sweep(7, 8, 0, 0, 1'b0, -1);
    check("div_mult_err_zero", err_count, 0);

    // Wrong stored SUB result.
    sweep(3, 3, 0, 0, 1'b0, -1);
    check("sub_err_one", err_count, 1);

    // Wrapping range 30, 31, 0, 1.
    sweep(30, 1, 0, 0, 1'b0, -1);

    // Five-cycle backpressure with an ignored start in the window.
    sweep(10, 12, 5, 5, 1'b1, -1);

    // Reset while the 2nd of 10 entries is presented, then a clean restart.
    sweep(10, 19, 0, 2, 1'b0, 1);
    sweep(10, 19, 0, 2, 1'b0, -1);

    // Full 32-entry sweep and a random range with random stalls.
    sweep(5, 4, 0, 3, 1'b0, -1);
    sweep($urandom_range(0, 31), $urandom_range(0, 31), 0, 4, 1'b0, -1);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
